// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and 8N1 frame constants
// common to the receiver and the paired transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } rx_state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int   DATA_BITS = 8;

endpackage

// File: rtl/uart_baud_timer.sv
// Free-running baud down-counter. A load restarts it at load_val. Reaching zero
// reloads BAUD_DIV-1 and raises a one-cycle registered tick on the following cycle.
module uart_baud_timer #(
    parameter int unsigned BAUD_DIV = 8192,
    parameter int          TW       = $clog2(BAUD_DIV)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    output logic          tick
);

    localparam logic [TW-1:0] RELOAD = TW'(BAUD_DIV - 1);

    logic [TW-1:0] cnt_q, cnt_d;
    logic          tick_q;

    // NOTE: cnt_d gets a default before any branch so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d = cnt_q - 1'b1;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q == '0) begin
            cnt_d = RELOAD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= !load && (cnt_q == '0);
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver: two-flop input synchroniser, mid-bit sampling FSM and a
// rdy/clr_rdy byte handshake with sticky framing and overrun flags.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 8192
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       frm_err,
    output logic       ovr_err,
    output logic       busy
);

    localparam int TW = $clog2(BAUD_DIV);

    logic            rx_meta_q, rx_s_q;
    rx_state_t       state_q;
    logic [3:0]      bit_cnt_q;
    logic [7:0]      shreg_q;
    logic [7:0]      rx_data_q;
    logic            rdy_q, frm_err_q, ovr_err_q, busy_q;
    logic            tmr_load, tick;

    // NOTE: the synchroniser resets to the idle level so leaving reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // The first tick after a start edge lands half a bit in, centring every later sample.
    assign tmr_load = (state_q == IDLE) && (rx_s_q == START_BIT);

    uart_baud_timer #(
        .BAUD_DIV (BAUD_DIV)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (TW'(BAUD_DIV / 2 - 1)),
        .tick     (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            rx_data_q <= '0;
            rdy_q     <= 1'b0;
            frm_err_q <= 1'b0;
            ovr_err_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            if (clr_rdy) begin
                rdy_q     <= 1'b0;
                ovr_err_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (rx_s_q == START_BIT) begin
                        state_q <= START;
                        busy_q  <= 1'b1;
                    end
                end

                START: begin
                    if (tick) begin
                        if (rx_s_q == START_BIT) begin
                            state_q   <= DATA;
                            bit_cnt_q <= '0;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end

                DATA: begin
                    if (tick) begin
                        shreg_q   <= {rx_s_q, shreg_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
                            state_q <= STOP;
                        end
                    end
                end

                STOP: begin
                    if (tick) begin
                        if (rx_s_q == STOP_BIT) begin
                            // A completing frame overrides a same-cycle clr_rdy.
                            rx_data_q <= shreg_q;
                            rdy_q     <= 1'b1;
                            frm_err_q <= 1'b0;
                            if (rdy_q && !clr_rdy) begin
                                ovr_err_q <= 1'b1;
                            end
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            frm_err_q <= 1'b1;
                            state_q   <= BRK;
                        end
                    end
                end

                BRK: begin
                    if (rx_s_q == STOP_BIT) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data = rx_data_q;
    assign rdy     = rdy_q;
    assign frm_err = frm_err_q;
    assign ovr_err = ovr_err_q;
    assign busy    = busy_q;

endmodule
